lcd_spi_driver: RTL and testbench



---
 rtl/lcd_spi_pkg.sv | 16 +
 rtl/lcd_spi_driver_if.sv | 23 ++
 rtl/lcd_spi_clk_en.sv | 35 +++
 rtl/lcd_spi_driver.sv | 109 ++++++++++
 tb/tb_lcd_spi_driver.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/lcd_spi_pkg.sv
// rtl/lcd_spi_pkg.sv - shared types and constants for the LCD SPI driver
package lcd_spi_pkg;

   localparam int LCD_SPI_WORD_W      = 9;
   localparam int LCD_SPI_DC_BIT      = 8;
   localparam int LCD_SPI_PAYLOAD_W   = 8;
   localparam int LCD_SPI_CLK_DIV_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_HOLD
   } lcd_spi_state_e;

endpackage

// File: rtl/lcd_spi_driver_if.sv
// rtl/lcd_spi_driver_if.sv - sequencer request/done handshake and panel pins
interface lcd_spi_driver_if;
   import lcd_spi_pkg::*;

   logic                      en_i;
   logic [LCD_SPI_WORD_W-1:0] data_i;
   logic                      done_o;
   logic                      lcd_cs_o;
   logic                      lcd_dc_o;
   logic                      lcd_scl_o;
   logic                      lcd_sda_o;

   modport master (
      output en_i, data_i,
      input  done_o, lcd_cs_o, lcd_dc_o, lcd_scl_o, lcd_sda_o
   );

   modport slave (
      input  en_i, data_i,
      output done_o, lcd_cs_o, lcd_dc_o, lcd_scl_o, lcd_sda_o
   );

endinterface

// File: rtl/lcd_spi_clk_en.sv
// rtl/lcd_spi_clk_en.sv - half-period counter, one-cycle tick every CLK_DIV cycles while enabled
module lcd_spi_clk_en #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic tick_o
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick_o = en_i && (cnt_q == CNT_MAX);

   // Restart from zero on every tick so each FSM phase lasts exactly CLK_DIV cycles.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!en_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/lcd_spi_driver.sv
// rtl/lcd_spi_driver.sv - write-only 4-wire SPI master sending one 9-bit LCD word per request
// Optional build macro LCD_SPI_LSB_FIRST_EN: shift payload LSB first instead of MSB first.
module lcd_spi_driver
   import lcd_spi_pkg::*;
#(
   parameter int CLK_DIV = LCD_SPI_CLK_DIV_DEF
) (
   input  logic             clk,
   input  logic             rst,
   lcd_spi_driver_if.slave  bus
);

   lcd_spi_state_e               state_q;
   logic [LCD_SPI_PAYLOAD_W-1:0] sr_q;
   logic [2:0]                   bit_cnt_q;
   logic                         cs_q;
   logic                         dc_q;
   logic                         scl_q;
   logic                         sda_q;
   logic                         done_q;
   logic                         tick;
   logic                         first_bit;
   logic                         next_bit;
   logic [LCD_SPI_PAYLOAD_W-1:0] sr_shifted;

   lcd_spi_clk_en #(.CLK_DIV(CLK_DIV)) u_clk_en (
      .clk    (clk),
      .rst    (rst),
      .en_i   (state_q != ST_IDLE),
      .tick_o (tick)
   );

`ifdef LCD_SPI_LSB_FIRST_EN
   assign first_bit  = bus.data_i[0];
   assign next_bit   = sr_q[1];
   assign sr_shifted = sr_q >> 1;
`else
   assign first_bit  = bus.data_i[LCD_SPI_PAYLOAD_W-1];
   assign next_bit   = sr_q[LCD_SPI_PAYLOAD_W-2];
   assign sr_shifted = sr_q << 1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         sr_q      <= '0;
         bit_cnt_q <= '0;
         cs_q      <= 1'b1;
         dc_q      <= 1'b0;
         scl_q     <= 1'b0;
         sda_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               cs_q  <= 1'b1;
               scl_q <= 1'b0;
               if (bus.en_i) begin
                  sr_q      <= bus.data_i[LCD_SPI_PAYLOAD_W-1:0];
                  cs_q      <= 1'b0;
                  dc_q      <= bus.data_i[LCD_SPI_DC_BIT];
                  sda_q     <= first_bit;
                  bit_cnt_q <= 3'd7;
                  state_q   <= ST_SHIFT_LO;
               end
            end
            ST_SHIFT_LO: begin
               scl_q <= 1'b0;
               if (tick) begin
                  scl_q   <= 1'b1;
                  state_q <= ST_SHIFT_HI;
               end
            end
            ST_SHIFT_HI: begin
               scl_q <= 1'b1;
               if (tick) begin
                  // SDA advances together with the SCL falling edge, never while SCL is high.
                  scl_q <= 1'b0;
                  if (bit_cnt_q == 3'd0) begin
                     state_q <= ST_HOLD;
                  end else begin
                     sda_q     <= next_bit;
                     sr_q      <= sr_shifted;
                     bit_cnt_q <= bit_cnt_q - 3'd1;
                     state_q   <= ST_SHIFT_LO;
                  end
               end
            end
            ST_HOLD: begin
               scl_q <= 1'b0;
               if (tick) begin
                  cs_q    <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.done_o    = done_q;
   assign bus.lcd_cs_o  = cs_q;
   assign bus.lcd_dc_o  = dc_q;
   assign bus.lcd_scl_o = scl_q;
   assign bus.lcd_sda_o = sda_q;

endmodule

// File: tb/tb_lcd_spi_driver.sv
// tb/tb_lcd_spi_driver.sv - directed self-checking bench for lcd_spi_driver with CLK_DIV=2
module tb_lcd_spi_driver;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   lcd_spi_driver_if bus ();

   lcd_spi_driver #(.CLK_DIV(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] exp_order(input logic [8:0] d);
      logic [7:0] r;
      for (int k = 0; k < 8; k++) begin
`ifdef LCD_SPI_LSB_FIRST_EN
         r[k] = d[k];
`else
         r[k] = d[7-k];
`endif
      end
      return r;
   endfunction

   // Pulses en_i for one cycle (edge 0) and observes the pins after each edge c = 0..max_c-1.
   task automatic run_word(input logic [8:0] d, input bit inject, input int max_c,
                           output logic [7:0] bits, output int pulses, output int cs_low,
                           output int bad_hi, output int bad_dc, output int bad_chg,
                           output int done_edge, output int done_cnt);
      logic prev_scl, prev_sda, prev_dc;
      int   hi_len;
      bits = '0; pulses = 0; cs_low = 0; bad_hi = 0; bad_dc = 0; bad_chg = 0;
      done_edge = -1; done_cnt = 0; hi_len = 0;
      bus.data_i = d;
      bus.en_i   = 1'b1;
      @(posedge clk); #1;
      bus.en_i = 1'b0;
      prev_scl = 1'b0;
      prev_sda = bus.lcd_sda_o;
      prev_dc  = bus.lcd_dc_o;
      for (int c = 0; c < max_c; c++) begin
         if (bus.done_o) begin
            done_cnt++;
            if (done_edge < 0) done_edge = c;
         end
         if (!bus.lcd_cs_o) begin
            cs_low++;
            if (bus.lcd_dc_o !== d[8]) bad_dc++;
         end
         if (bus.lcd_scl_o && !prev_scl) begin
            if (pulses < 8) bits[pulses] = bus.lcd_sda_o;
            pulses++;
            hi_len = 1;
         end else if (bus.lcd_scl_o) begin
            hi_len++;
         end else if (prev_scl && hi_len != 2) begin
            bad_hi++;
         end
         if (bus.lcd_scl_o && (bus.lcd_sda_o !== prev_sda || bus.lcd_dc_o !== prev_dc)) bad_chg++;
         prev_scl = bus.lcd_scl_o;
         prev_sda = bus.lcd_sda_o;
         prev_dc  = bus.lcd_dc_o;
         if (inject) begin
            bus.en_i   = (c == 5 || c == 20);
            bus.data_i = ~d;
         end
         @(posedge clk); #1;
      end
      bus.en_i = 1'b0;
   endtask

   task automatic test_reset();
      int busy;
      bus.en_i = 1'b0;
      bus.data_i = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++; if (bus.lcd_cs_o !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b expected 1", bus.lcd_cs_o); end
      checks++; if (bus.lcd_scl_o !== 1'b0) begin errors++; $display("FAIL reset_scl: got %b expected 0", bus.lcd_scl_o); end
      checks++; if (bus.lcd_sda_o !== 1'b0) begin errors++; $display("FAIL reset_sda: got %b expected 0", bus.lcd_sda_o); end
      checks++; if (bus.lcd_dc_o !== 1'b0) begin errors++; $display("FAIL reset_dc: got %b expected 0", bus.lcd_dc_o); end
      checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done_o); end
      busy = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (bus.lcd_cs_o !== 1'b1 || bus.lcd_scl_o !== 1'b0 || bus.done_o !== 1'b0 ||
             bus.lcd_sda_o !== 1'b0 || bus.lcd_dc_o !== 1'b0) busy++;
      end
      checks++; if (busy != 0) begin errors++; $display("FAIL reset_idle: got %0d busy cycles expected 0", busy); end
   endtask

   task automatic test_word(input logic [8:0] d, input string name);
      logic [7:0] bits;
      int pulses, cs_low, bad_hi, bad_dc, bad_chg, done_edge, done_cnt;
      run_word(d, 1'b0, 40, bits, pulses, cs_low, bad_hi, bad_dc, bad_chg, done_edge, done_cnt);
      checks++; if (bits !== exp_order(d)) begin errors++; $display("FAIL %s_bits: got %b expected %b (bit0 first)", name, bits, exp_order(d)); end
      checks++; if (pulses != 8) begin errors++; $display("FAIL %s_pulses: got %0d expected 8", name, pulses); end
      checks++; if (bad_hi != 0) begin errors++; $display("FAIL %s_scl_high_len: got %0d bad pulses expected 0", name, bad_hi); end
      checks++; if (cs_low != 34) begin errors++; $display("FAIL %s_cs_low: got %0d expected 34", name, cs_low); end
      checks++; if (bad_dc != 0) begin errors++; $display("FAIL %s_dc: got %0d bad cycles expected 0", name, bad_dc); end
      checks++; if (bad_chg != 0) begin errors++; $display("FAIL %s_sda_stable: got %0d changes with scl high expected 0", name, bad_chg); end
      checks++; if (done_edge != 34) begin errors++; $display("FAIL %s_done_edge: got %0d expected 34", name, done_edge); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done_cnt: got %0d expected 1", name, done_cnt); end
   endtask

   task automatic test_ignore_en();
      logic [7:0] bits;
      int pulses, cs_low, bad_hi, bad_dc, bad_chg, done_edge, done_cnt;
      run_word(9'h133, 1'b1, 40, bits, pulses, cs_low, bad_hi, bad_dc, bad_chg, done_edge, done_cnt);
      checks++; if (bits !== exp_order(9'h133)) begin errors++; $display("FAIL ignore_bits: got %b expected %b", bits, exp_order(9'h133)); end
      checks++; if (bad_dc != 0) begin errors++; $display("FAIL ignore_dc: got %0d bad cycles expected 0", bad_dc); end
      checks++; if (cs_low != 34) begin errors++; $display("FAIL ignore_cs_low: got %0d expected 34", cs_low); end
      checks++; if (done_edge != 34) begin errors++; $display("FAIL ignore_done_edge: got %0d expected 34", done_edge); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL ignore_done_cnt: got %0d expected 1", done_cnt); end
   endtask

   task automatic test_back_to_back();
      int cs_high, done_cnt, d0, d1, tail_busy;
      logic cs_at34;
      cs_high = 0; done_cnt = 0; d0 = -1; d1 = -1; tail_busy = 0; cs_at34 = 1'b0;
      bus.data_i = 9'h1C3;
      bus.en_i   = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < 76; c++) begin
         if (c <= 68 && bus.lcd_cs_o) cs_high++;
         if (c == 34) cs_at34 = bus.lcd_cs_o;
         if (bus.done_o) begin
            done_cnt++;
            if (d0 < 0) d0 = c; else if (d1 < 0) d1 = c;
         end
         if (c >= 70 && bus.lcd_cs_o !== 1'b1) tail_busy++;
         if (c == 69) bus.en_i = 1'b0;
         @(posedge clk); #1;
      end
      bus.en_i = 1'b0;
      checks++; if (cs_high != 1 || cs_at34 !== 1'b1) begin errors++; $display("FAIL b2b_cs_gap: got %0d high cycles (cs@34=%b) expected 1 at cycle 34", cs_high, cs_at34); end
      checks++; if (d0 != 34) begin errors++; $display("FAIL b2b_done_first: got %0d expected 34", d0); end
      checks++; if (d1 != 69) begin errors++; $display("FAIL b2b_done_second: got %0d expected 69", d1); end
      checks++; if (done_cnt != 2 || tail_busy != 0) begin errors++; $display("FAIL b2b_stop: got done=%0d tail_busy=%0d expected 2 and 0", done_cnt, tail_busy); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] bits;
      int pulses, cs_low, bad_hi, bad_dc, bad_chg, done_edge, done_cnt, stray;
      bus.data_i = 9'h1FF;
      bus.en_i   = 1'b1;
      @(posedge clk); #1;
      bus.en_i = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (bus.lcd_cs_o !== 1'b1) begin errors++; $display("FAIL mid_rst_cs: got %b expected 1", bus.lcd_cs_o); end
      checks++; if (bus.lcd_scl_o !== 1'b0) begin errors++; $display("FAIL mid_rst_scl: got %b expected 0", bus.lcd_scl_o); end
      checks++; if (bus.lcd_sda_o !== 1'b0) begin errors++; $display("FAIL mid_rst_sda: got %b expected 0", bus.lcd_sda_o); end
      checks++; if (bus.lcd_dc_o !== 1'b0) begin errors++; $display("FAIL mid_rst_dc: got %b expected 0", bus.lcd_dc_o); end
      checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %b expected 0", bus.done_o); end
      stray = 0;
      for (int c = 0; c < 50; c++) begin
         if (bus.done_o !== 1'b0 || bus.lcd_cs_o !== 1'b1) stray++;
         @(posedge clk); #1;
      end
      checks++; if (stray != 0) begin errors++; $display("FAIL mid_rst_quiet: got %0d active cycles expected 0", stray); end
      run_word(9'h0C6, 1'b0, 40, bits, pulses, cs_low, bad_hi, bad_dc, bad_chg, done_edge, done_cnt);
      checks++; if (bits !== exp_order(9'h0C6)) begin errors++; $display("FAIL mid_rst_after_bits: got %b expected %b", bits, exp_order(9'h0C6)); end
      checks++; if (done_edge != 34 || done_cnt != 1) begin errors++; $display("FAIL mid_rst_after_done: got edge %0d count %0d expected 34 and 1", done_edge, done_cnt); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus.en_i = 1'b0;
      bus.data_i = '0;
      test_reset();
      test_word(9'h15A, "data");
      test_word(9'h0A5, "cmd");
      test_ignore_en();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
